spi_master_core: RTL and testbench
==================================

SPI_MASTER_CORE -- requirements
Module: spi_master_core

Interface
REQ-001 Parameter: DIV_W, default 4, width of the SCLK divider field.
REQ-002 i_PCLK  in  1  single clock; all state on rising edge.
REQ-003 i_PRESET  in  1  reset, asynchronous, active-high.
REQ-004 i_WR0..i_WR3  in  1 each  one-cycle write strobes: CONFIG, TX, RXCLR, CMD.
REQ-005 i_DR0..i_DR3  in  1 each  one-cycle read strobes: STATE, RX, CONFIG readback, reserved.
REQ-006 i_PWDATA  in  8  write data, valid in the cycle a WR strobe is high.
REQ-007 o_PRDATA  out  8  read data.
REQ-008 o_SCLK  out  1  serial clock.
REQ-009 o_MOSI  out  1  serial data out.
REQ-010 i_MISO  in  1  serial data in, sampled directly (no synchroniser).
REQ-011 o_SS_n  out  1  slave select, active-low.
REQ-012 o_IRQ  out  1  high while STATE.DONE=1 and CONFIG.IE=1.

Function
REQ-013 CONFIG fields: [7:4] DIV, [3] IE, [2] LSBF, [1] CPHA, [0] CPOL. An i_WR0 while BUSY=1 is ignored.
REQ-014 SCLK half-period is DIV+1 PCLK cycles; DIV=0 gives SCLK = PCLK/2.
REQ-015 i_WR1 loads TXHOLD and sets TXFULL; a write while TXFULL=1 overwrites TXHOLD.
REQ-016 CMD bits: [0] START, [1] CLRDONE, [2] CLROVR; the remaining bits are ignored.
REQ-017 FSM states: IDLE, LOAD, SHIFT, DONE.
REQ-018 IDLE->LOAD on i_WR3 with START=1 when TXFULL=1; START is ignored when TXFULL=0 or in any other state.
REQ-019 LOAD (1 cycle): copy TXHOLD into the shifter; clear TXFULL; drive o_SS_n low; present the first data bit on o_MOSI (MSB, or LSB if LSBF=1); set BUSY.
REQ-020 SHIFT: generate exactly 16 SCLK edges, starting from the CPOL idle level.
REQ-021 CPHA=0: sample i_MISO on odd (leading) edges; shift o_MOSI on even (trailing) edges.
REQ-022 CPHA=1: shift o_MOSI on leading edges; sample i_MISO on trailing edges.
REQ-023 After the 16th edge, go to DONE.
REQ-024 DONE (1 cycle): write the shifter into RXDATA; set RXFULL and DONE; set OVR if RXFULL was already 1; o_SS_n high; clear BUSY; next state IDLE.
REQ-025 STATE byte: {4'b0, OVR, DONE, RXFULL, BUSY, TXFULL} truncated to [7:0] as [4]OVR [3]DONE [2]RXFULL [1]BUSY [0]TXFULL; [7:5]=0.
REQ-026 o_PRDATA is combinational: i_DR0 selects STATE, i_DR1 selects RXDATA, i_DR2 selects CONFIG; otherwise 8'h00. i_DR0 has priority over i_DR1, i_DR1 over i_DR2.
REQ-027 i_DR1 or i_WR2 clears RXFULL at the clock edge.
REQ-028 i_DR1 in the same cycle as DONE: the new data is stored, RXFULL stays 1 and OVR is not set.
REQ-029 CLRDONE and CLROVR clear their flags; if DONE is being set in the same cycle, the set wins.
REQ-030 o_SCLK equals CPOL whenever the FSM is not in SHIFT.
REQ-031 o_MOSI holds its last value between transfers.

Reset
REQ-032 On i_PRESET: FSM goes to IDLE; CONFIG, TXHOLD, RXDATA, shifter, edge counter and divider = 0; all flags = 0; o_SCLK=0, o_MOSI=0, o_SS_n=1, o_IRQ=0.
REQ-033 Reset asserted mid-transfer aborts the transfer immediately, with no RXDATA update.

Structure
REQ-034 A shared package holds the FSM state encoding, the CONFIG/CMD/STATE bit-index constants and the edge count 16.
REQ-035 One sub-module, spi_clk_gen, holds the divider counter and SCLK toggle and outputs leading/trailing edge pulses; the shifter and FSM stay in the top level.

Verification
REQ-036 Reset, then CONFIG=8'h00, TX=8'hA5, CMD=8'h01 with i_MISO looped to o_MOSI -> SS_n low for 16 PCLK cycles, RXDATA=8'hA5, STATE=8'h0C.
REQ-037 CONFIG=8'h33 (DIV=3, CPHA=1, CPOL=1), TX=8'h3C -> SCLK idles high, half-period 4 cycles, MOSI bit order 0,0,1,1,1,1,0,0, o_IRQ=0.
REQ-038 CONFIG=8'h0C (LSBF=1, IE=1), TX=8'h01 -> first MOSI bit 1, o_IRQ high after DONE, CMD=8'h02 drops o_IRQ.
REQ-039 Two transfers without reading RX -> STATE.OVR=1 and RXDATA = second byte; CMD=8'h04 clears OVR.
REQ-040 i_PRESET pulsed during the 5th SCLK edge -> o_SS_n=1 next cycle, STATE=8'h00, RXDATA unchanged at 8'h00.
REQ-041 START with TXFULL=0, and CONFIG write while BUSY -> no transfer starts, and CONFIG readback via i_DR2 keeps its old value.

Source files
------------

// File: rtl/spi_master_core_pkg.sv
// Shared definitions for the SPI master core: FSM encoding and register bit positions.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package spi_master_core_pkg;

   // Transfer sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // CONFIG register bit positions ([7:4] is the divider field)
   localparam int CFG_CPOL    = 0;
   localparam int CFG_CPHA    = 1;
   localparam int CFG_LSBF    = 2;
   localparam int CFG_IE      = 3;
   localparam int CFG_DIV_LSB = 4;

   // CMD register bit positions
   localparam int CMD_START   = 0;
   localparam int CMD_CLRDONE = 1;
   localparam int CMD_CLROVR  = 2;

   // STATE register bit positions
   localparam int STS_TXFULL = 0;
   localparam int STS_BUSY   = 1;
   localparam int STS_RXFULL = 2;
   localparam int STS_DONE   = 3;
   localparam int STS_OVR    = 4;

   // SCLK edges per byte (8 leading + 8 trailing)
   localparam logic [4:0] EDGE_COUNT = 5'd16;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: toggles SCLK every DIV+1 PCLK cycles while enabled, flags leading/trailing edges.
// Latency: edge pulse is combinational in the cycle before SCLK visibly toggles.
// Backpressure: none; SCLK parks at CPOL whenever disabled.
module spi_clk_gen
   import spi_master_core_pkg::*;
#(
   parameter int DIV_W = 4
) (
   input  logic             i_PCLK,
   input  logic             i_PRESET,
   input  logic             en,
   input  logic             cpol,
   input  logic [DIV_W-1:0] div,
   output logic             sclk,
   output logic             lead,
   output logic             trail
);

   logic [DIV_W-1:0] div_cnt;
   logic             sclk_q;
   logic             tick;

   assign tick = en && (div_cnt == div);

   // Divider counter and SCLK toggle; restart from the idle level when disabled
   always_ff @(posedge i_PCLK or posedge i_PRESET) begin
      if (i_PRESET) begin
         div_cnt <= '0;
         sclk_q  <= 1'b0;
      end else if (!en) begin
         div_cnt <= '0;
         sclk_q  <= cpol;
      end else if (tick) begin
         div_cnt <= '0;
         sclk_q  <= ~sclk_q;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // A toggle away from the idle level is a leading edge, back towards it a trailing edge
   assign lead  = tick && (sclk_q == cpol);
   assign trail = tick && (sclk_q != cpol);
   assign sclk  = en ? sclk_q : cpol;

endmodule

// File: rtl/spi_master_core.sv
// SPI master: register-strobe interface, one byte per START, modes 0-3, MSB/LSB first.
// Latency: 1 LOAD cycle + 16*(DIV+1) SHIFT cycles + 1 DONE cycle per byte.
// Backpressure: START ignored unless idle with TXHOLD full; CONFIG writes ignored while busy.
module spi_master_core
   import spi_master_core_pkg::*;
#(
   parameter int DIV_W = 4
) (
   input  logic       i_PCLK,
   input  logic       i_PRESET,
   input  logic       i_WR0,
   input  logic       i_WR1,
   input  logic       i_WR2,
   input  logic       i_WR3,
   input  logic       i_DR0,
   input  logic       i_DR1,
   input  logic       i_DR2,
   input  logic       i_DR3,
   input  logic [7:0] i_PWDATA,
   output logic [7:0] o_PRDATA,
   output logic       o_SCLK,
   output logic       o_MOSI,
   input  logic       i_MISO,
   output logic       o_SS_n,
   output logic       o_IRQ
);

   state_t     state_q, state_d;
   logic [7:0] cfg_q, txhold_q, rxdata_q, sh_q;
   logic [4:0] edge_cnt_q;
   logic       txfull_q, rxfull_q, done_q, ovr_q;
   logic       mosi_q, ss_n_q;
   logic       busy, start_req, lead, trail, edge_p, last_edge;
   logic       cpha, lsbf, sample_now, drive_now, done_set;
   logic [7:0] status;
   logic       unused_dr3;

   assign unused_dr3 = i_DR3;

   assign busy      = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
   assign start_req = (state_q == ST_IDLE) && i_WR3 && i_PWDATA[CMD_START] && txfull_q;
   assign edge_p    = lead || trail;
   assign last_edge = edge_p && (edge_cnt_q == EDGE_COUNT - 5'd1);
   assign cpha      = cfg_q[CFG_CPHA];
   assign lsbf      = cfg_q[CFG_LSBF];
   assign done_set  = (state_q == ST_DONE);
   // The final trailing edge in CPHA=0 must not shift, so MOSI keeps the last data bit
   assign sample_now = cpha ? trail : lead;
   assign drive_now  = cpha ? lead  : (trail && !last_edge);

   spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
      .i_PCLK   (i_PCLK),
      .i_PRESET (i_PRESET),
      .en       (state_q == ST_SHIFT),
      .cpol     (cfg_q[CFG_CPOL]),
      .div      (DIV_W'(cfg_q[7:CFG_DIV_LSB])),
      .sclk     (o_SCLK),
      .lead     (lead),
      .trail    (trail)
   );

   // FSM state register
   always_ff @(posedge i_PCLK or posedge i_PRESET) begin
      if (i_PRESET) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_req) state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_SHIFT;
         ST_SHIFT: if (last_edge) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // CONFIG is frozen for the duration of a transfer
   always_ff @(posedge i_PCLK or posedge i_PRESET) begin
      if (i_PRESET)           cfg_q <= 8'h00;
      else if (i_WR0 && !busy) cfg_q <= i_PWDATA;
   end

   // TX holding register; a new write in the LOAD cycle re-arms TXFULL
   always_ff @(posedge i_PCLK or posedge i_PRESET) begin
      if (i_PRESET) begin
         txhold_q <= 8'h00;
         txfull_q <= 1'b0;
      end else begin
         if (state_q == ST_LOAD) txfull_q <= 1'b0;
         if (i_WR1) begin
            txhold_q <= i_PWDATA;
            txfull_q <= 1'b1;
         end
      end
   end

   // Shifter, edge counter, MOSI and slave select
   always_ff @(posedge i_PCLK or posedge i_PRESET) begin
      if (i_PRESET) begin
         sh_q       <= 8'h00;
         edge_cnt_q <= 5'd0;
         mosi_q     <= 1'b0;
         ss_n_q     <= 1'b1;
      end else if (state_q == ST_LOAD) begin
         sh_q       <= txhold_q;
         edge_cnt_q <= 5'd0;
         mosi_q     <= lsbf ? txhold_q[0] : txhold_q[7];
         ss_n_q     <= 1'b0;
      end else if (state_q == ST_SHIFT) begin
         if (edge_p)     edge_cnt_q <= edge_cnt_q + 5'd1;
         if (sample_now) sh_q <= lsbf ? {i_MISO, sh_q[7:1]} : {sh_q[6:0], i_MISO};
         if (drive_now)  mosi_q <= lsbf ? sh_q[0] : sh_q[7];
         if (last_edge)  ss_n_q <= 1'b1;
      end
   end

   // Receive data and status flags; flag sets in DONE win over same-cycle clears
   always_ff @(posedge i_PCLK or posedge i_PRESET) begin
      if (i_PRESET) begin
         rxdata_q <= 8'h00;
         rxfull_q <= 1'b0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         if (i_DR1 || i_WR2)                  rxfull_q <= 1'b0;
         if (i_WR3 && i_PWDATA[CMD_CLRDONE])  done_q   <= 1'b0;
         if (i_WR3 && i_PWDATA[CMD_CLROVR])   ovr_q    <= 1'b0;
         if (done_set) begin
            rxdata_q <= sh_q;
            rxfull_q <= 1'b1;
            done_q   <= 1'b1;
            if (rxfull_q && !i_DR1) ovr_q <= 1'b1;
         end
      end
   end

   assign status = {3'b000, ovr_q, done_q, rxfull_q, busy, txfull_q};

   // Read mux, DR0 > DR1 > DR2
   always_comb begin
      o_PRDATA = 8'h00;
      if (i_DR0)      o_PRDATA = status;
      else if (i_DR1) o_PRDATA = rxdata_q;
      else if (i_DR2) o_PRDATA = cfg_q;
   end

   assign o_MOSI = mosi_q;
   assign o_SS_n = ss_n_q;
   assign o_IRQ  = done_q && cfg_q[CFG_IE];

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: register sequences with hand-computed results.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_master_core;

   logic       i_PCLK = 1'b0;
   logic       i_PRESET;
   logic       i_WR0, i_WR1, i_WR2, i_WR3;
   logic       i_DR0, i_DR1, i_DR2, i_DR3;
   logic [7:0] i_PWDATA;
   logic [7:0] o_PRDATA;
   logic       o_SCLK, o_MOSI, o_SS_n, o_IRQ;
   logic       i_MISO;
   logic       loop_en, miso_drv;

   int n_cmp = 0;
   int n_bad = 0;

   assign i_MISO = loop_en ? o_MOSI : miso_drv;

   always #5 i_PCLK = ~i_PCLK;

   spi_master_core #(.DIV_W(4)) dut (
      .i_PCLK   (i_PCLK),
      .i_PRESET (i_PRESET),
      .i_WR0    (i_WR0),
      .i_WR1    (i_WR1),
      .i_WR2    (i_WR2),
      .i_WR3    (i_WR3),
      .i_DR0    (i_DR0),
      .i_DR1    (i_DR1),
      .i_DR2    (i_DR2),
      .i_DR3    (i_DR3),
      .i_PWDATA (i_PWDATA),
      .o_PRDATA (o_PRDATA),
      .o_SCLK   (o_SCLK),
      .o_MOSI   (o_MOSI),
      .i_MISO   (i_MISO),
      .o_SS_n   (o_SS_n),
      .o_IRQ    (o_IRQ)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge i_PCLK);
   endtask

   task automatic wr(input int idx, input logic [7:0] d);
      @(negedge i_PCLK);
      i_PWDATA = d;
      case (idx)
         0: i_WR0 = 1'b1;
         1: i_WR1 = 1'b1;
         2: i_WR2 = 1'b1;
         default: i_WR3 = 1'b1;
      endcase
      @(negedge i_PCLK);
      {i_WR0, i_WR1, i_WR2, i_WR3} = 4'b0000;
      i_PWDATA = 8'h00;
   endtask

   task automatic rd(input int idx, output logic [7:0] d);
      @(negedge i_PCLK);
      case (idx)
         0: i_DR0 = 1'b1;
         1: i_DR1 = 1'b1;
         default: i_DR2 = 1'b1;
      endcase
      #1 d = o_PRDATA;
      @(negedge i_PCLK);
      {i_DR0, i_DR1, i_DR2} = 3'b000;
   endtask

   task automatic wait_ss(input logic lvl, input string tag);
      int g;
      g = 0;
      while (o_SS_n !== lvl && g < 2000) begin
         @(negedge i_PCLK);
         g++;
      end
      check_val(tag, o_SS_n, lvl);
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] bits;
      logic       prev;
      int         cnt, cyc, nchg, half, guard;

      i_PRESET = 1'b1;
      {i_WR0, i_WR1, i_WR2, i_WR3} = 4'b0000;
      {i_DR0, i_DR1, i_DR2, i_DR3} = 4'b0000;
      i_PWDATA = 8'h00;
      loop_en  = 1'b1;
      miso_drv = 1'b0;
      cycles(3);

      // Reset state
      check_val("rst_ss_n", o_SS_n, 1'b1);
      check_val("rst_sclk", o_SCLK, 1'b0);
      check_val("rst_mosi", o_MOSI, 1'b0);
      check_val("rst_irq",  o_IRQ,  1'b0);
      i_PRESET = 1'b0;
      rd(0, d); check_val("rst_state", d, 8'h00);
      rd(2, d); check_val("rst_cfg",   d, 8'h00);
      rd(1, d); check_val("rst_rx",    d, 8'h00);

      // Mode 0, DIV=0, loopback A5
      wr(0, 8'h00);
      wr(1, 8'hA5);
      wr(3, 8'h01);
      wait_ss(1'b0, "t1_ss_lo");
      cnt = 0;
      while (o_SS_n == 1'b0 && cnt < 500) begin
         cnt++;
         @(negedge i_PCLK);
      end
      check_val("t1_ss_low_cycles", cnt, 16);
      cycles(2);
      rd(0, d); check_val("t1_state", d, 8'h0C);
      rd(1, d); check_val("t1_rx",    d, 8'hA5);
      rd(0, d); check_val("t1_state_after_rd", d, 8'h08);

      // Mode 3, DIV=3, MSB first 3C, MISO held low
      loop_en  = 1'b0;
      miso_drv = 1'b0;
      wr(0, 8'h33);
      check_val("t2_sclk_idle", o_SCLK, 1'b1);
      wr(1, 8'h3C);
      wr(3, 8'h01);
      wait_ss(1'b0, "t2_ss_lo");
      prev = o_SCLK; cyc = 0; nchg = 0; half = 0; bits = 8'h00; guard = 0;
      while (o_SS_n == 1'b0 && guard < 300) begin
         @(negedge i_PCLK);
         guard++;
         cyc++;
         if (o_SCLK != prev) begin
            nchg++;
            if (nchg == 2) half = cyc;
            cyc = 0;
            if (o_SCLK == 1'b1) bits = {bits[6:0], o_MOSI};
            prev = o_SCLK;
         end
      end
      check_val("t2_edges",    nchg, 16);
      check_val("t2_half_per", half, 4);
      check_val("t2_mosi_seq", bits, 8'h3C);
      cycles(2);
      check_val("t2_sclk_after", o_SCLK, 1'b1);
      check_val("t2_irq", o_IRQ, 1'b0);
      rd(0, d); check_val("t2_state", d, 8'h0C);
      rd(1, d); check_val("t2_rx",    d, 8'h00);
      wr(3, 8'h02);

      // Mode 0, LSB first with IRQ enabled, MISO held high
      miso_drv = 1'b1;
      wr(0, 8'h0C);
      wr(1, 8'h01);
      wr(3, 8'h01);
      wait_ss(1'b0, "t3_ss_lo");
      check_val("t3_first_mosi", o_MOSI, 1'b1);
      wait_ss(1'b1, "t3_ss_hi");
      cycles(2);
      check_val("t3_irq_set", o_IRQ, 1'b1);
      rd(0, d); check_val("t3_state", d, 8'h0C);
      wr(3, 8'h02);
      check_val("t3_irq_clr", o_IRQ, 1'b0);
      rd(1, d); check_val("t3_rx", d, 8'hFF);

      // Two transfers without reading RX -> overrun
      loop_en = 1'b1;
      wr(0, 8'h00);
      wr(1, 8'h11);
      wr(3, 8'h01);
      wait_ss(1'b0, "t4a_ss_lo");
      wait_ss(1'b1, "t4a_ss_hi");
      cycles(2);
      rd(0, d); check_val("t4_state1", d, 8'h0C);
      wr(1, 8'h22);
      wr(3, 8'h01);
      wait_ss(1'b0, "t4b_ss_lo");
      wait_ss(1'b1, "t4b_ss_hi");
      cycles(2);
      rd(0, d); check_val("t4_state_ovr", d, 8'h1C);
      rd(1, d); check_val("t4_rx", d, 8'h22);
      wr(3, 8'h04);
      rd(0, d); check_val("t4_state_clrovr", d, 8'h08);

      // Reset pulsed during the 5th SCLK edge
      i_PRESET = 1'b1;
      cycles(2);
      i_PRESET = 1'b0;
      wr(0, 8'h00);
      wr(1, 8'h5A);
      wr(3, 8'h01);
      wait_ss(1'b0, "t5_ss_lo");
      cycles(4);
      i_PRESET = 1'b1;
      @(posedge i_PCLK);
      #1 i_PRESET = 1'b0;
      @(negedge i_PCLK);
      check_val("t5_ss_n", o_SS_n, 1'b1);
      check_val("t5_sclk", o_SCLK, 1'b0);
      rd(0, d); check_val("t5_state", d, 8'h00);
      rd(1, d); check_val("t5_rx",    d, 8'h00);

      // START without TX data, then CONFIG write while busy
      wr(3, 8'h01);
      cycles(5);
      check_val("t6_no_start_ss", o_SS_n, 1'b1);
      rd(0, d); check_val("t6_no_start_state", d, 8'h00);
      wr(0, 8'h20);
      wr(1, 8'h66);
      wr(1, 8'h77);
      rd(0, d); check_val("t6_txfull", d, 8'h01);
      wr(3, 8'h01);
      wait_ss(1'b0, "t6_ss_lo");
      wr(0, 8'hFF);
      rd(2, d); check_val("t6_cfg_busy", d, 8'h20);
      rd(0, d); check_val("t6_state_busy", d, 8'h02);
      wait_ss(1'b1, "t6_ss_hi");
      cycles(2);
      rd(2, d); check_val("t6_cfg_after", d, 8'h20);
      rd(1, d); check_val("t6_rx_overwrite", d, 8'h77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
